// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: opcode encodings, sequencer states and op classes.
// Used by alu_sequencer and alu_op_decode.
package alu_ctrl_pkg;

  localparam logic [4:0] OP_LDW  = 5'b00000;
  localparam logic [4:0] OP_LDWI = 5'b00001;
  localparam logic [4:0] OP_STW  = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BRN  = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_DONE  = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_ARITH   = 3'd0,
    CLS_MULDIV  = 3'd1,
    CLS_BRANCH  = 3'd2,
    CLS_JAL     = 3'd3,
    CLS_PASS    = 3'd4,
    CLS_HALT    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } op_class_t;

  // Classes whose result goes back through Z.
  function automatic logic class_loads_z(input op_class_t cls);
    return (cls == CLS_ARITH) || (cls == CLS_JAL);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode to op-class mapping; unassigned encodings report CLS_ILLEGAL.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class
);

  // Pure lookup from the ALU opcode encoding.
  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OP_LDW, OP_LDWI, OP_STW, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI, OP_NEG, OP_NOT:
        op_class = CLS_ARITH;
      OP_MUL, OP_DIV:
        op_class = CLS_MULDIV;
      OP_BRN, OP_JR:
        op_class = CLS_BRANCH;
      OP_JAL:
        op_class = CLS_JAL;
      OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP:
        op_class = CLS_PASS;
      OP_HALT:
        op_class = CLS_HALT;
      default:
        op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Execute-phase controller: IDLE/LATCH/EXEC/WB/DONE/HALT with registered strobes.
// Optional build macro ALU_SEQ_ILLEGAL_TRAP_EN completes opcodes 11011-11111 as illegal.
module alu_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 32'sd2,
  parameter int DIV_CYCLES = 32'sd32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       issue_valid,
  output logic       issue_ready,
  input  logic [4:0] opcode,
  input  logic       brn_flag,
  output logic [4:0] alu_op,
  output logic       op_latch,
  output logic       inc_pc,
  output logic       z_load,
  output logic       hi_load,
  output logic       lo_load,
  output logic       pc_load,
  output logic       done_valid,
  input  logic       done_ready,
  output logic       done_illegal,
  output logic       halted
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 32'sd1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  state_t          r_state;
  state_t          w_state_next;
  logic [4:0]      r_opcode;
  op_class_t       r_class;
  op_class_t       w_dec_class;
  op_class_t       w_in_class;
  op_class_t       w_cls;
  logic [CNT_W-1:0] r_cnt;
  logic            w_accept;
  logic            w_wb_next;

  logic r_issue_ready, r_op_latch, r_inc_pc, r_z_load, r_hi_load, r_lo_load;
  logic r_pc_load, r_done_valid, r_done_illegal, r_halted;
  logic w_issue_ready, w_op_latch, w_inc_pc, w_z_load, w_hilo_load;
  logic w_pc_load, w_done_valid, w_done_illegal, w_halted;

  // The branch condition goes to the ALU directly; the sequencer does not act on it.
  logic w_unused_brn;
  assign w_unused_brn = brn_flag;

  alu_op_decode u_decode (
    .opcode   (opcode),
    .op_class (w_dec_class)
  );

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  assign w_in_class = w_dec_class;
`else
  // Without the trap, unassigned opcodes behave exactly like nop.
  always_comb begin
    w_in_class = w_dec_class;
    if (w_dec_class == CLS_ILLEGAL) begin
      w_in_class = CLS_PASS;
    end else begin
      w_in_class = w_dec_class;
    end
  end
`endif

  assign w_accept = issue_valid && (r_state == ST_IDLE);

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (w_in_class == CLS_ILLEGAL)) begin
          w_state_next = ST_DONE;
        end else if (w_accept) begin
          w_state_next = ST_LATCH;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_LATCH: w_state_next = ST_EXEC;
      ST_EXEC: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_next = ST_WB;
        end else begin
          w_state_next = ST_EXEC;
        end
      end
      ST_WB: begin
        if (r_class == CLS_HALT) begin
          w_state_next = ST_HALT;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (done_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      ST_HALT: w_state_next = ST_HALT;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output values for the coming state, so every output can be a flop aligned with its state.
  always_comb begin
    w_cls          = (r_state == ST_IDLE) ? w_in_class : r_class;
    w_wb_next      = (w_state_next == ST_WB);
    w_issue_ready  = (w_state_next == ST_IDLE);
    w_op_latch     = (w_state_next == ST_LATCH);
    w_inc_pc       = (w_state_next == ST_EXEC);
    w_z_load       = w_wb_next && class_loads_z(w_cls);
    w_hilo_load    = w_wb_next && (w_cls == CLS_MULDIV);
    w_pc_load      = w_wb_next && (w_cls != CLS_HALT);
    w_done_valid   = (w_state_next == ST_DONE);
    w_halted       = (w_state_next == ST_HALT);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    w_done_illegal = w_done_valid && (w_cls == CLS_ILLEGAL);
`else
    w_done_illegal = 1'b0;
`endif
  end

  // State, captured opcode/class and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_opcode       <= OP_NOP;
      r_class        <= CLS_PASS;
      r_issue_ready  <= 1'b1;
      r_op_latch     <= 1'b0;
      r_inc_pc       <= 1'b0;
      r_z_load       <= 1'b0;
      r_hi_load      <= 1'b0;
      r_lo_load      <= 1'b0;
      r_pc_load      <= 1'b0;
      r_done_valid   <= 1'b0;
      r_done_illegal <= 1'b0;
      r_halted       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_opcode <= opcode;
        r_class  <= w_in_class;
      end else begin
        r_opcode <= r_opcode;
        r_class  <= r_class;
      end
      r_issue_ready  <= w_issue_ready;
      r_op_latch     <= w_op_latch;
      r_inc_pc       <= w_inc_pc;
      r_z_load       <= w_z_load;
      r_hi_load      <= w_hilo_load;
      r_lo_load      <= w_hilo_load;
      r_pc_load      <= w_pc_load;
      r_done_valid   <= w_done_valid;
      r_done_illegal <= w_done_illegal;
      r_halted       <= w_halted;
    end
  end

  // Latency counter: loaded in LATCH, counts down in EXEC and saturates at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= CNT_ZERO;
    end else if (r_state == ST_LATCH) begin
      case (r_opcode)
        OP_MUL:  r_cnt <= MUL_LOAD;
        OP_DIV:  r_cnt <= DIV_LOAD;
        default: r_cnt <= CNT_ZERO;
      endcase
    end else if ((r_state == ST_EXEC) && (r_cnt != CNT_ZERO)) begin
      r_cnt <= r_cnt - CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign issue_ready  = r_issue_ready;
  assign alu_op       = r_opcode;
  assign op_latch     = r_op_latch;
  assign inc_pc       = r_inc_pc;
  assign z_load       = r_z_load;
  assign hi_load      = r_hi_load;
  assign lo_load      = r_lo_load;
  assign pc_load      = r_pc_load;
  assign done_valid   = r_done_valid;
  assign done_illegal = r_done_illegal;
  assign halted       = r_halted;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: cycle-by-cycle timeline model per issued opcode.
module tb_alu_sequencer;

  localparam int MUL_C = 2;
  localparam int DIV_C = 32;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       issue_valid = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic       brn_flag = 1'b0;
  logic       done_ready = 1'b1;
  logic       issue_ready, op_latch, inc_pc, z_load, hi_load, lo_load, pc_load;
  logic       done_valid, done_illegal, halted;
  logic [4:0] alu_op;

  logic [14:0] obs;
  assign obs = {issue_ready, alu_op, op_latch, inc_pc, z_load, hi_load, lo_load,
                pc_load, done_valid, done_illegal, halted};

  // Vector every output takes in reset / in idle with nothing pending.
  localparam logic [14:0] IDLE_VEC = {1'b1, 5'b11001, 9'b0};

  int n_cmp = 0;
  int n_bad = 0;

  // Per-run observations (cycle index after the accept edge, -1 if never seen).
  int first_latch, first_z, first_hl, first_pc, first_dv, first_ready, first_halt;
  int dv_count, inc_count;

  alu_sequencer #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .brn_flag(brn_flag), .alu_op(alu_op), .op_latch(op_latch),
    .inc_pc(inc_pc), .z_load(z_load), .hi_load(hi_load), .lo_load(lo_load),
    .pc_load(pc_load), .done_valid(done_valid), .done_ready(done_ready),
    .done_illegal(done_illegal), .halted(halted)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: opcode classes from the instruction list.
  function automatic int exec_len(input logic [4:0] op);
    if (op == 5'd14) return MUL_C;
    if (op == 5'd15) return DIV_C;
    return 1;
  endfunction

  function automatic bit is_illegal(input logic [4:0] op);
    return op >= 5'd27;
  endfunction

  function automatic bit writes_z(input logic [4:0] op);
    return (op <= 5'd13) || (op == 5'd16) || (op == 5'd17) || (op == 5'd20);
  endfunction

  function automatic bit writes_hilo(input logic [4:0] op);
    return (op == 5'd14) || (op == 5'd15);
  endfunction

  // Expected outputs k cycles after the accept edge, with done_ready low for 'stall' cycles.
  function automatic logic [14:0] exp_at(input logic [4:0] op, input int k, input int stall);
    bit trap, halt, wbk, dv, rdy;
    int wb, dv_start;
    trap     = TRAP && is_illegal(op);
    halt     = (op == 5'd26);
    wb       = 2 + exec_len(op);
    dv_start = trap ? 1 : wb + 1;
    wbk      = !trap && (k == wb);
    dv       = !halt && (k >= dv_start) && (k <= dv_start + stall);
    rdy      = !halt && (k > dv_start + stall);
    return {rdy, op, (!trap && k == 1), (!trap && k >= 2 && k < wb),
            (wbk && writes_z(op)), (wbk && writes_hilo(op)), (wbk && writes_hilo(op)),
            (wbk && !halt), dv, (dv && trap), (halt && k > wb)};
  endfunction

  // Issue one opcode from IDLE and compare every output on every cycle until idle again.
  task automatic run_op(input logic [4:0] op, input int stall, input string tag);
    int last, wb, dv_start;
    logic [14:0] exp;
    wb       = 2 + exec_len(op);
    dv_start = (TRAP && is_illegal(op)) ? 1 : wb + 1;
    last     = (op == 5'd26) ? wb + 3 : dv_start + stall + 1;
    first_latch = -1; first_z = -1; first_hl = -1; first_pc = -1;
    first_dv = -1; first_ready = -1; first_halt = -1; dv_count = 0; inc_count = 0;
    n_cmp++;
    if (issue_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_before_issue: got %b, want 1", tag, issue_ready);
    end
    issue_valid = 1'b1;
    opcode      = op;
    done_ready  = (stall == 0);
    for (int k = 1; k <= last; k++) begin
      @(posedge clock); #1;
      exp = exp_at(op, k, stall);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL %s op=%b k=%0d: outputs got %b, want %b", tag, op, k, obs, exp);
      end
      if (op_latch && first_latch < 0) first_latch = k;
      if (z_load && first_z < 0) first_z = k;
      if (hi_load && lo_load && first_hl < 0) first_hl = k;
      if (pc_load && first_pc < 0) first_pc = k;
      if (done_valid && first_dv < 0) first_dv = k;
      if (issue_ready && first_ready < 0) first_ready = k;
      if (halted && first_halt < 0) first_halt = k;
      dv_count  += int'(done_valid);
      inc_count += int'(inc_pc);
      issue_valid = (op == 5'd26) && (k >= wb);
      opcode      = 5'($urandom);
      brn_flag    = 1'($urandom);
      done_ready  = (k >= dv_start + stall);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (obs !== IDLE_VEC) begin
      n_bad++;
      $display("FAIL reset_values: got %b, want %b", obs, IDLE_VEC);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if (obs !== IDLE_VEC) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %b, want %b", obs, IDLE_VEC);
    end
  endtask

  task automatic test_add();
    run_op(5'b00011, 0, "add");
    n_cmp++;
    if (first_latch !== 1 || first_z !== 3 || first_pc !== 3 || first_dv !== 4 || first_ready !== 5) begin
      n_bad++;
      $display("FAIL add_timing: latch/z/pc/done/ready at %0d/%0d/%0d/%0d/%0d, want 1/3/3/4/5",
               first_latch, first_z, first_pc, first_dv, first_ready);
    end
  endtask

  task automatic test_mul();
    run_op(5'b01110, 0, "mul");
    n_cmp++;
    if (first_hl !== 4 || first_z !== -1 || inc_count !== 2) begin
      n_bad++;
      $display("FAIL mul_timing: hilo at %0d z at %0d exec %0d, want 4 -1 2",
               first_hl, first_z, inc_count);
    end
  endtask

  task automatic test_div_stall();
    run_op(5'b01111, 3, "div_stall");
    n_cmp++;
    if (first_hl !== 34 || dv_count !== 4 || first_ready !== 39) begin
      n_bad++;
      $display("FAIL div_timing: hilo at %0d done cycles %0d ready at %0d, want 34 4 39",
               first_hl, dv_count, first_ready);
    end
  endtask

  task automatic test_illegal();
    run_op(5'b11111, 0, "illegal");
    n_cmp++;
    if (first_dv !== (TRAP ? 1 : 4) || first_pc !== (TRAP ? -1 : 3) || first_latch !== (TRAP ? -1 : 1)) begin
      n_bad++;
      $display("FAIL illegal_timing: done/pc/latch at %0d/%0d/%0d, trap=%0d",
               first_dv, first_pc, first_latch, TRAP);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    for (int i = 0; i < 30; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd26) op = 5'd3;
      run_op(op, int'($urandom_range(0, 2)), "b2b");
    end
  endtask

  task automatic test_reset_mid_div();
    logic [14:0] exp;
    issue_valid = 1'b1;
    opcode      = 5'b01111;
    done_ready  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock); #1;
      exp = exp_at(5'b01111, k, 0);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL div_pre_reset k=%0d: got %b, want %b", k, obs, exp);
      end
      issue_valid = 1'b0;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_cmp++;
    if (obs !== IDLE_VEC) begin
      n_bad++;
      $display("FAIL mid_div_reset: got %b, want %b", obs, IDLE_VEC);
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      n_cmp++;
      if (obs !== IDLE_VEC) begin
        n_bad++;
        $display("FAIL after_mid_reset k=%0d: got %b, want %b", k, obs, IDLE_VEC);
      end
    end
  endtask

  task automatic test_halt();
    run_op(5'b11010, 0, "halt");
    n_cmp++;
    if (first_halt !== 4 || first_pc !== -1 || first_ready !== -1) begin
      n_bad++;
      $display("FAIL halt_timing: halted/pc/ready at %0d/%0d/%0d, want 4/-1/-1",
               first_halt, first_pc, first_ready);
    end
    issue_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_cmp++;
    if (obs !== IDLE_VEC) begin
      n_bad++;
      $display("FAIL halt_reset: got %b, want %b", obs, IDLE_VEC);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (obs !== IDLE_VEC) begin
      n_bad++;
      $display("FAIL halt_reset_idle: got %b, want %b", obs, IDLE_VEC);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div_stall();
    test_illegal();
    test_back_to_back();
    test_reset_mid_div();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
